// File: rtl/forthsuper_pkg.sv
// Shared types for the ss_io data-stack channel: request opcodes, pick FSM states
// and the register-held pick index boundary.
package forthsuper_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        REPL = 2'd3
    } ss_op_t;

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_RD   = 2'd1,
        SS_OUT  = 2'd2
    } ss_sts_t;

    // Deepest pick index served straight from the TOS/NOS registers.
    localparam int SS_NOP_IDX = 1;

endpackage

// File: rtl/ss_ram.sv
// Flop array for the cells below NOS: one write port, one combinational read
// port for POP refill and one registered read port for picks.
module ss_ram
    import forthsuper_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int N   = 14,
    parameter int AW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DSZ-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [DSZ-1:0] rdata,
    input  logic           ren,
    input  logic [AW-1:0]  qaddr,
    output logic [DSZ-1:0] qdata
);

    logic [DSZ-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (ren)
            qdata <= mem[qaddr];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Forth parameter stack responder: TOS/NOS in registers, deeper cells in ss_ram.
// Optional build macro DS_GUARD_EN adds a sticky err output and blocks over/underflow.
module data_stack
    import forthsuper_pkg::*;
#(
    parameter int DSZ   = 32,
    parameter int DEPTH = 16,
    parameter int CSZ   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vld,
    input  logic [1:0]     op,
    input  logic           pick,
    input  logic [CSZ-1:0] idx,
    input  logic [DSZ-1:0] din,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [DSZ-1:0] pck,
    output logic           pck_vld,
    output logic [CSZ-1:0] cnt,
    output logic           bsy
`ifdef DS_GUARD_EN
    ,
    output logic           err
`endif
);

    localparam int N  = DEPTH - 2;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CSZ-1:0] CNT_FULL = CSZ'(DEPTH);

    ss_sts_t        state, state_nx;
    ss_op_t         op_e;
    logic [AW-1:0]  wp, wp_inc, wp_dec, ridx, ridx_nx;
    logic           oor_q;
    logic [DSZ-1:0] ram_rd, ram_q;

    logic accept, do_pick, do_op, is_push, is_pop, is_repl, blk;
    logic push_ok, pop_ok, pick_ok, pick_reg, pick_oor, cnt_ge2, cnt_ge3;

    assign op_e     = ss_op_t'(op);
    assign accept   = vld & (state == SS_IDLE);
    assign do_pick  = accept & pick;
    assign do_op    = accept & ~pick;
    // REPL on an empty stack has nothing to replace, so it acts as a PUSH.
    assign is_push  = do_op & ((op_e == PUSH) | ((op_e == REPL) & (cnt == '0)));
    assign is_pop   = do_op & (op_e == POP);
    assign is_repl  = do_op & (op_e == REPL) & (cnt != '0);
    assign pick_oor = idx >= cnt;
    assign pick_reg = idx <= CSZ'(SS_NOP_IDX);
    assign cnt_ge2  = cnt >= CSZ'(2);
    assign cnt_ge3  = cnt >= CSZ'(3);

`ifdef DS_GUARD_EN
    assign blk = (is_push & (cnt == CNT_FULL)) | ((is_pop | do_pick) & (cnt == '0));
`else
    assign blk = 1'b0;
`endif

    assign push_ok = is_push & ~blk;
    assign pop_ok  = is_pop & ~blk;
    assign pick_ok = do_pick & ~blk;
    assign bsy     = (state != SS_IDLE);

    // Array pointers wrap modulo DEPTH-2, which need not be a power of two.
    assign wp_inc = (wp == AW'(N - 1)) ? '0 : wp + AW'(1);
    assign wp_dec = (wp == '0) ? AW'(N - 1) : wp - AW'(1);

    // Cell idx lives idx-1 slots below the write pointer.
    always_comb begin
        logic [CSZ-1:0] d;
        logic [CSZ-1:0] w;
        logic [CSZ-1:0] r;
        d = idx - CSZ'(1);
        if (d >= CSZ'(N))
            d = d - CSZ'(N);
        w = CSZ'(wp);
        r = (w >= d) ? (w - d) : (w + CSZ'(N) - d);
        ridx_nx = pick_oor ? '0 : AW'(r);
    end

    ss_ram #(.DSZ(DSZ), .N(N), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (push_ok & cnt_ge2),
        .waddr (wp),
        .wdata (nos),
        .raddr (wp_dec),
        .rdata (ram_rd),
        .ren   (state == SS_RD),
        .qaddr (ridx),
        .qdata (ram_q)
    );

    always_comb begin
        state_nx = state;
        case (state)
            SS_IDLE: if (pick_ok && !pick_reg) state_nx = SS_RD;
            SS_RD:   state_nx = SS_OUT;
            SS_OUT:  state_nx = SS_IDLE;
            default: state_nx = SS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SS_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos     <= '0;
            nos     <= '0;
            pck     <= '0;
            pck_vld <= 1'b0;
            cnt     <= '0;
            wp      <= '0;
        end else begin
            pck_vld <= 1'b0;
            if (push_ok) begin
                nos <= tos;
                tos <= din;
                if (cnt != CNT_FULL)
                    cnt <= cnt + CSZ'(1);
                if (cnt_ge2)
                    wp <= wp_inc;
            end else if (pop_ok) begin
                tos <= nos;
                nos <= cnt_ge3 ? ram_rd : '0;
                if (cnt != '0)
                    cnt <= cnt - CSZ'(1);
                if (cnt_ge3)
                    wp <= wp_dec;
            end else if (is_repl) begin
                tos <= din;
            end
            if (pick_ok && pick_reg) begin
                pck     <= pick_oor ? '0 : ((idx == '0) ? tos : nos);
                pck_vld <= 1'b1;
            end
            if (state == SS_OUT) begin
                pck     <= oor_q ? '0 : ram_q;
                pck_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pick_ok && !pick_reg) begin
            ridx  <= ridx_nx;
            oor_q <= pick_oor;
        end
    end

`ifdef DS_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (blk)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_data_stack.sv
// Randomized bench for data_stack against a queue-based stack model (front = TOS).
// Build with or without DS_GUARD_EN; the model follows the same macro.
module tb_data_stack;
    import forthsuper_pkg::*;

    localparam int DSZ   = 32;
    localparam int DEPTH = 16;
    localparam int CSZ   = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst_n;
    logic           vld;
    logic [1:0]     op;
    logic           pick;
    logic [CSZ-1:0] idx;
    logic [DSZ-1:0] din;
    logic [DSZ-1:0] tos, nos, pck;
    logic           pck_vld;
    logic [CSZ-1:0] cnt;
    logic           bsy;
`ifdef DS_GUARD_EN
    logic           err;
`endif

    data_stack #(.DSZ(DSZ), .DEPTH(DEPTH), .CSZ(CSZ)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .op      (op),
        .pick    (pick),
        .idx     (idx),
        .din     (din),
        .tos     (tos),
        .nos     (nos),
        .pck     (pck),
        .pck_vld (pck_vld),
        .cnt     (cnt),
        .bsy     (bsy)
`ifdef DS_GUARD_EN
        ,
        .err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    bit          err_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_cell(input int i);
        return (i < q.size()) ? q[i] : 32'h0;
    endfunction

    task automatic model_op(input logic [1:0] o, input logic [31:0] d);
        case (o)
            2'd1: begin
                if (q.size() == DEPTH) begin
`ifdef DS_GUARD_EN
                    err_m = 1'b1;
`else
                    void'(q.pop_back());
                    q.push_front(d);
`endif
                end else begin
                    q.push_front(d);
                end
            end
            2'd2: begin
                if (q.size() == 0) begin
`ifdef DS_GUARD_EN
                    err_m = 1'b1;
`endif
                end else begin
                    void'(q.pop_front());
                end
            end
            2'd3: begin
                if (q.size() == 0) q.push_front(d);
                else q[0] = d;
            end
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        check({tag, "_tos"}, tos, m_cell(0));
        check({tag, "_nos"}, nos, m_cell(1));
        check({tag, "_cnt"}, cnt, 64'(q.size()));
        check({tag, "_bsy"}, bsy, 0);
`ifdef DS_GUARD_EN
        check({tag, "_err"}, err, err_m);
`endif
    endtask

    task automatic op_step(input logic [1:0] o, input logic [31:0] d);
        vld = 1'b1; pick = 1'b0; op = o; din = d; idx = CSZ'($urandom_range(0, 31));
        @(posedge clk); #1;
        vld = 1'b0;
        model_op(o, d);
        check("op_pvld", pck_vld, 0);
        check_state("op");
    endtask

    task automatic idle_step();
        vld = 1'b0; pick = $urandom_range(0, 1) == 1; op = 2'($urandom_range(0, 3)); din = $urandom;
        @(posedge clk); #1;
        check("idle_pvld", pck_vld, 0);
        check_state("idle");
    endtask

    task automatic pick_step(input logic [CSZ-1:0] ix, input bit hold);
        logic [31:0] expv;
        int sz;
        sz   = q.size();
        expv = (int'(ix) < sz) ? q[ix] : 32'h0;
        vld = 1'b1; pick = 1'b1; idx = ix; op = 2'd1; din = $urandom;
        @(posedge clk); #1;
        if (hold) pick = 1'b0;
        else vld = 1'b0;
`ifdef DS_GUARD_EN
        if (sz == 0) begin
            vld = 1'b0;
            err_m = 1'b1;
            check("pick_empty_pvld", pck_vld, 0);
            check_state("pick_empty");
            return;
        end
`endif
        if (ix <= 1) begin
            vld = 1'b0;
            check("pick1_pvld", pck_vld, 1);
            check("pick1_pck", pck, expv);
        end else begin
            check("pickc1_bsy", bsy, 1);
            check("pickc1_pvld", pck_vld, 0);
            @(posedge clk); #1;
            check("pickc2_bsy", bsy, 1);
            check("pickc2_pvld", pck_vld, 0);
            @(posedge clk); #1;
            vld = 1'b0;
            check("pickc3_pvld", pck_vld, 1);
            check("pickc3_pck", pck, expv);
        end
        check_state("pick");
    endtask

    task automatic do_reset();
        @(negedge clk);
        vld = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        err_m = 1'b0;
        check_state("rst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit drain;
        rst_n = 1'b0; vld = 1'b0; op = 2'd0; pick = 1'b0; idx = '0; din = '0; err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tos", tos, 0);
        check("rst_nos", nos, 0);
        check("rst_pck", pck, 0);
        check("rst_pvld", pck_vld, 0);
        check("rst_cnt", cnt, 0);
        check("rst_bsy", bsy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push/pop ordering
        op_step(2'd1, 32'h11);
        op_step(2'd1, 32'h22);
        op_step(2'd1, 32'h33);
        check("d_tos33", tos, 32'h33);
        check("d_nos22", nos, 32'h22);
        check("d_cnt3", cnt, 3);
        op_step(2'd2, '0);
        check("d_pop1", tos, 32'h22);
        op_step(2'd2, '0);
        check("d_pop2", tos, 32'h11);
        op_step(2'd2, '0);
        check("d_pop3", tos, 32'h0);
        check("d_cnt0", cnt, 0);

        // Fill, picks at both ends, pick with held PUSH during bsy
        for (int i = 1; i <= DEPTH; i++) op_step(2'd1, 32'(i));
        check("d_full", cnt, DEPTH);
        pick_step(CSZ'(15), 1'b0);
        check("d_pick15", pck, 32'h1);
        pick_step(CSZ'(0), 1'b0);
        check("d_pick0", pck, 32'h10);
        pick_step(CSZ'(6), 1'b1);
        pick_step(CSZ'(DEPTH), 1'b0);

        // Overflow
        op_step(2'd1, 32'hFF);
`ifdef DS_GUARD_EN
        check("d_ovf_err", err, 1);
        check("d_ovf_tos", tos, 32'h10);
`else
        check("d_ovf_tos", tos, 32'hFF);
        check("d_ovf_cnt", cnt, DEPTH);
        pick_step(CSZ'(15), 1'b0);
        check("d_ovf_deep", pck, 32'h2);
`endif

        // REPL mid-stack and on empty
        do_reset();
        for (int i = 0; i < 5; i++) op_step(2'd1, $urandom);
        op_step(2'd3, 32'hAB);
        check("d_repl_tos", tos, 32'hAB);
        check("d_repl_cnt", cnt, 5);
        do_reset();
        op_step(2'd3, 32'h7);
        check("d_repl0_tos", tos, 32'h7);
        check("d_repl0_cnt", cnt, 1);

        // Underflow
        do_reset();
        op_step(2'd2, '0);
        check("d_unf_tos", tos, 0);
        check("d_unf_cnt", cnt, 0);
`ifdef DS_GUARD_EN
        check("d_unf_err", err, 1);
`endif

        // Randomized traffic, alternating fill-biased and drain-biased phases
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drain = ((i / 80) % 2) == 1;
            r = $urandom_range(0, 15);
            if (r < 6) op_step(drain ? 2'd2 : 2'd1, $urandom);
            else if (r < 9) op_step(drain ? 2'd1 : 2'd2, $urandom);
            else if (r < 11) op_step(2'd3, $urandom);
            else if (r == 11) op_step(2'd0, $urandom);
            else if (r == 12) idle_step();
            else pick_step(CSZ'($urandom_range(0, DEPTH + 1)), $urandom_range(0, 1) == 1);
        end

        // Reset asserted while the pick is in SS_RD
        do_reset();
        for (int i = 0; i < 8; i++) op_step(2'd1, $urandom);
        vld = 1'b1; pick = 1'b1; idx = CSZ'(6); op = 2'd1; din = 32'hDEAD;
        @(posedge clk); #1;
        pick = 1'b0;
        check("mr_bsy", bsy, 1);
        check("mr_cnt8", cnt, 8);
        rst_n = 1'b0;
        #1;
        vld = 1'b0;
        q.delete();
        err_m = 1'b0;
        check("mr_tos", tos, 0);
        check("mr_cnt", cnt, 0);
        check("mr_bsy0", bsy, 0);
        check("mr_pvld", pck_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mr_post_pvld", pck_vld, 0);
            check_state("mr_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Responder end of the ss_io data-stack channel; the inner interpreter issues push/pop/replace/pick requests.
- Holds the Forth parameter stack:
  - top-of-stack (TOS) and next-on-stack (NOS) in registers, so both are always visible with zero latency;
  - deeper cells in a flop array.
- Single-cycle for push/pop/replace; multi-cycle pick with a busy handshake.

Parameters:
- DSZ, 32, data cell width in bits.
- DEPTH, 16, total cell capacity including TOS and NOS; power of two, at least 4.
- CSZ, $clog2(DEPTH)+1, width of the cell count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- vld  in  1  request valid; sampled on posedge clk when bsy=0
- op  in  2  ss_op_t: NOP=0, PUSH=1, POP=2, REPL=3
- pick  in  1  with vld, requests a pick (op ignored)
- idx  in  CSZ  pick depth; 0=TOS, 1=NOS, 2..cnt-1=array
- din  in  DSZ  data for PUSH/REPL
- tos  out  DSZ  top of stack
- nos  out  DSZ  next on stack
- pck  out  DSZ  pick result
- pck_vld  out  1  one-cycle pulse, pck valid
- cnt  out  CSZ  cells held, 0..DEPTH
- bsy  out  1  1 while a pick is in progress; requests are ignored

Behaviour:
- Reset (async assert, sync deassert):
  - tos=0, nos=0, pck=0, pck_vld=0, cnt=0, bsy=0, FSM=SS_IDLE.
  - Array contents undefined.
- Internal pointer sp is the array write index and equals max(cnt-2,0).
- All updates take effect at the posedge where vld=1 and bsy=0; results are visible the next cycle.
- PUSH:
  - mem[sp]<=nos when cnt>=2; nos<=tos; tos<=din; cnt++.
- POP:
  - tos<=nos; nos<=mem[sp-1] when cnt>=3, else 0; cnt--.
- REPL: tos<=din; cnt unchanged; a REPL with cnt=0 behaves as PUSH.
- NOP, or vld=0: no change.
- FSM, ss_sts_t:
  - SS_IDLE:
    - vld&pick with idx<=1: pck<=tos or nos, pck_vld=1 next cycle, stays SS_IDLE (latency 1).
    - vld&pick with idx>=2: latch ridx=sp-(idx-1), bsy<=1, go SS_RD.
  - SS_RD: registered array read into pck; go SS_OUT.
  - SS_OUT: pck_vld=1, bsy<=0, go SS_IDLE.
  - Total array-pick latency is 3 cycles from request to pck_vld; no stack mutation during a pick.
- pick and op together: pick wins; op is dropped.
- idx>=cnt: pck returns 0, same latency.
- Overflow (PUSH at cnt=DEPTH) and underflow (POP at cnt=0): see DS_GUARD_EN.
- Array index arithmetic is modulo DEPTH-2.
- rst_n low mid-pick: immediate return to reset values; no pck_vld.

Optional Feature:
- Macro DS_GUARD_EN.
- Defined:
  - Output err, 1 bit, sticky, reset 0.
  - PUSH at full, or POP/pick-out-of-range at empty, sets err and the operation is suppressed; state unchanged.
  - err clears only on reset.
- Undefined:
  - No err port.
  - Overflow wraps: the oldest array cell is overwritten, cnt saturates at DEPTH.
  - Underflow: tos/nos shift in 0, cnt saturates at 0.

Decomposition:
- Package forthsuper_pkg holds:
  - ss_op_t (2-bit enum NOP/PUSH/POP/REPL);
  - ss_sts_t (SS_IDLE/SS_RD/SS_OUT);
  - localparam SS_NOP_IDX for idx encodings.
- One sub-module, ss_ram: DEPTH-2 x DSZ flop array with one write port and one combinational read port (for POP refill), plus one registered read port (for pick).

Test Plan:
- Reset then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, cnt=3; POP x3 -> tos sequence 0x22, 0x11, 0; cnt=0.
- PUSH 1..16 (DEPTH=16) -> cnt=16; pick idx=15 -> bsy high 2 cycles, pck=1 with pck_vld 3 cycles after request; pick idx=0 -> pck=16 in 1 cycle.
- REPL 0xAB at cnt=5 -> tos=0xAB, nos unchanged, cnt=5; REPL 0x7 at cnt=0 -> tos=7, cnt=1.
- Full at DEPTH, PUSH 0xFF -> with DS_GUARD_EN: err=1 and tos unchanged; without: tos=0xFF, cnt=16, deepest cell lost.
- POP at cnt=0 -> guard: err=1; no guard: tos=0, cnt=0.
- Pick idx=6 at cnt=8, with a PUSH and vld held during bsy, then rst_n pulsed low in SS_RD -> PUSH ignored while bsy; after reset cnt=0, bsy=0, no pck_vld.
